// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and a register/bus read port: first-word-fall-through,
// sticky overrun on dropped words. Optional threshold interrupt under UART_RX_FIFO_THRESH_IRQ_EN.
module uart_rx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_done,
    input  logic                 rx_error,
    input  logic                 rd_en,
    input  logic                 clr_overrun,
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    input  logic [CW-1:0]        rx_thresh,
    output logic                 irq,
`endif
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_err,
    output logic                 empty,
    output logic                 full,
    output logic [CW-1:0]        count,
    output logic                 overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      count_nx_s;
    logic               overrun_r;
    logic               overrun_nx_s;
    logic               empty_s;
    logic               full_s;
    logic               wr_s;
    logic               pop_s;
    logic               drop_s;
    logic [DATA_BITS:0] head_s;

    assign empty_s = (count_r == {CW{1'b0}});
    assign full_s  = (count_r == CW'(DEPTH));

    // Accept/pop/drop decisions; a pop frees a slot so a write into a full FIFO still lands.
    always_comb begin
        pop_s  = rd_en & ~empty_s;
        wr_s   = rx_done & (~full_s | rd_en);
        drop_s = rx_done & full_s & ~rd_en;
    end

    // Next-state occupancy and sticky overrun (a new drop beats a clear).
    always_comb begin
        count_nx_s = count_r;
        case ({wr_s, pop_s})
            2'b10:   count_nx_s = count_r + CW'(1'b1);
            2'b01:   count_nx_s = count_r - CW'(1'b1);
            default: count_nx_s = count_r;
        endcase
        if (drop_s) begin
            overrun_nx_s = 1'b1;
        end else if (clr_overrun) begin
            overrun_nx_s = 1'b0;
        end else begin
            overrun_nx_s = overrun_r;
        end
    end

    // Pointer, count and overrun registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r   <= count_nx_s;
            overrun_r <= overrun_nx_s;
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (!rst && wr_s) begin
            mem_r[wr_ptr_r] <= {rx_error, rx_data};
        end
    end

    // Head entry presented with zero read latency, forced to zero when empty.
    always_comb begin
        if (empty_s) begin
            head_s = {(DATA_BITS+1){1'b0}};
        end else begin
            head_s = mem_r[rd_ptr_r];
        end
    end

    assign rd_data = head_s[DATA_BITS-1:0];
    assign rd_err  = head_s[DATA_BITS];
    assign empty   = empty_s;
    assign full    = full_s;
    assign count   = count_r;
    assign overrun = overrun_r;

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic irq_r;

    // Interrupt registered from next-state values so it rises with the landing write.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= overrun_nx_s |
                     ((rx_thresh != {CW{1'b0}}) && (count_nx_s >= rx_thresh));
        end
    end

    assign irq = irq_r;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;
    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 16;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DATA_BITS-1:0] rx_data = '0;
    logic                 rx_done = 1'b0;
    logic                 rx_error = 1'b0;
    logic                 rd_en = 1'b0;
    logic                 clr_overrun = 1'b0;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_err;
    logic                 empty;
    logic                 full;
    logic [CW-1:0]        count;
    logic                 overrun;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic [CW-1:0]        rx_thresh = '0;
    logic                 irq;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: entries as {err, data}, oldest first.
    logic [DATA_BITS:0] m_q[$];
    bit                 m_ov = 1'b0;
    bit                 m_irq = 1'b0;

    uart_rx_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rx_error(rx_error),
        .rd_en(rd_en), .clr_overrun(clr_overrun),
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        .rx_thresh(rx_thresh), .irq(irq),
`endif
        .rd_data(rd_data), .rd_err(rd_err), .empty(empty), .full(full),
        .count(count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance model at the edge, return 1 time unit after.
    task automatic cycle(input bit done, input logic [7:0] d, input bit err,
                         input bit rd, input bit clr, input bit r);
        bit m_full, pop, wr, drop;
        int thr;
        rx_done = done; rx_data = d; rx_error = err;
        rd_en = rd; clr_overrun = clr; rst = r;
        @(posedge clk);
        thr = 0;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        thr = int'(rx_thresh);
`endif
        if (r) begin
            m_q.delete();
            m_ov  = 1'b0;
            m_irq = 1'b0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            pop  = rd && (m_q.size() > 0);
            wr   = done && (!m_full || rd);
            drop = done && m_full && !rd;
            if (pop) void'(m_q.pop_front());
            if (wr) m_q.push_back({err, d});
            if (drop) m_ov = 1'b1;
            else if (clr) m_ov = 1'b0;
            m_irq = m_ov || (thr != 0 && m_q.size() >= thr);
        end
        #1;
        rx_done = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0; rst = 1'b0;
    endtask

    // Continuous comparison of every output against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("count", int'(count), m_q.size());
            check("empty", int'(empty), int'(m_q.size() == 0));
            check("full", int'(full), int'(m_q.size() == DEPTH));
            check("overrun", int'(overrun), int'(m_ov));
            check("rd_data", int'(rd_data), (m_q.size() > 0) ? int'(m_q[0][DATA_BITS-1:0]) : 0);
            check("rd_err", int'(rd_err), (m_q.size() > 0) ? int'(m_q[0][DATA_BITS]) : 0);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
            check("irq", int'(irq), int'(m_irq));
`endif
        end
    end

    task automatic drain();
        for (int k = 0; k < DEPTH + 1; k++) begin
            if (m_q.size() > 0) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_en = 1'b1;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_rd_data", int'(rd_data), 0);

        // Single write then pop.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("a5_empty", int'(empty), 0);
        check("a5_count", int'(count), 1);
        check("a5_data", int'(rd_data), 8'hA5);
        check("a5_err", int'(rd_err), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("a5_pop_empty", int'(empty), 1);
        check("a5_pop_count", int'(count), 0);

        // Fill, overflow drop, ordered drain.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_full", int'(full), 1);
        check("ovf_count", int'(count), 16);
        check("ovf_overrun", int'(overrun), 1);
        for (int i = 0; i < 16; i++) begin
            check("ovf_order", int'(rd_data), i);
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("ovf_drained", int'(empty), 1);
        check("ovf_sticky", int'(overrun), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_cleared", int'(overrun), 0);

        // Write and pop together while full.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrpop_count", int'(count), 16);
        check("wrpop_overrun", int'(overrun), 0);
        for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrpop_last", int'(rd_data), 8'h55);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Error flag travels with its word; underflow is ignored.
        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        check("err_flag", int'(rd_err), 1);
        check("err_data", int'(rd_data), 8'h3C);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("underflow_count", int'(count), 0);
        check("underflow_empty", int'(empty), 1);

        // Interleaved traffic across pointer wrap.
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 8'($urandom), 1'($urandom), (i % 2) == 1, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_count5", int'(count), 5);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_empty", int'(empty), 1);

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        rx_thresh = CW'(4);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("irq_at3", int'(irq), 0);
        cycle(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        check("irq_at4", int'(irq), 1);
        rx_thresh = '0;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("irq_thr0", int'(irq), 0);
        drain();
`endif

        // Long randomized run with drops, clears and occasional resets.
        for (int i = 0; i < 600; i++) begin
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
            if ((i % 50) == 0) rx_thresh = CW'($urandom_range(0, DEPTH));
`endif
            cycle(($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70)),
                  ($urandom_range(0, 99) < 5), ($urandom_range(0, 299) == 0));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, the received word width (matches the upstream receiver).
REQ-002 SHALL have parameter DEPTH, default 16, the entry count (power of 2, >= 2); CW = $clog2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  DATA_BITS  word from the receiver, valid when rx_done=1.
REQ-006 SHALL have port rx_done  input  1  one-cycle write strobe from the receiver.
REQ-007 SHALL have port rx_error  input  1  receiver error flag, sampled with rx_done.
REQ-008 SHALL have port rd_en  input  1  pop request from the register/bus side.
REQ-009 SHALL have port clr_overrun  input  1  clears the sticky overrun flag.
REQ-010 SHALL have port rd_data  output  DATA_BITS  head-entry data (first-word-fall-through).
REQ-011 SHALL have port rd_err  output  1  error flag stored with the head entry.
REQ-012 SHALL have ports empty and full  output  1 each  occupancy status.
REQ-013 SHALL have port count  output  CW  number of stored entries, 0..DEPTH.
REQ-014 SHALL have port overrun  output  1  sticky flag: a word was dropped because the FIFO was full.

Function
REQ-015 SHALL store {rx_error, rx_data} at the tail on a posedge where rx_done=1 and the write is accepted.
REQ-016 SHALL accept a write when full=0, or when full=1 and rd_en=1 in the same cycle.
REQ-017 SHALL drop the word, leave contents unchanged, and set overrun=1 on the next edge when rx_done=1, full=1 and rd_en=0.
REQ-018 SHALL pop the head on a posedge where rd_en=1 and empty=0; rd_en while empty SHALL be ignored, with no pointer or count change.
REQ-019 SHALL drive rd_data/rd_err combinationally from the head entry whenever empty=0 (zero read latency); when empty=1, rd_data=0 and rd_err=0.
REQ-020 SHALL make written data visible at the head on the cycle after the write edge (write-to-read latency 1 cycle).
REQ-021 SHALL handle a simultaneous accepted write and valid pop in one cycle: count unchanged, both pointers advance.
REQ-022 SHALL use pointers that wrap from DEPTH-1 to 0; count is a registered counter (+1 on write only, -1 on pop only).
REQ-023 SHALL derive empty = (count==0) and full = (count==DEPTH).
REQ-024 SHALL keep overrun set until clr_overrun=1; if clr_overrun and a new drop occur in the same cycle, overrun SHALL remain 1 (set wins).

Reset
REQ-025 SHALL, on posedge clk with rst=1, clear pointers, count=0, overrun=0, empty=1, full=0, rd_data=0, rd_err=0; storage contents are don't-care.
REQ-026 SHALL give rst priority over rx_done, rd_en and clr_overrun in the same cycle; a reset mid-stream discards all entries.

Configuration
REQ-027 SHALL, with macro UART_RX_FIFO_THRESH_IRQ_EN defined, add input rx_thresh (CW bits) and output irq (1 bit, registered, reset 0), where irq = overrun | (rx_thresh!=0 && count>=rx_thresh), evaluated on next-state values.
REQ-028 SHALL, without UART_RX_FIFO_THRESH_IRQ_EN, omit the rx_thresh and irq ports and the irq logic entirely; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, then write 0xA5 (rx_error=0) -> next cycle empty=0, count=1, rd_data=0xA5, rd_err=0; rd_en=1 -> next cycle empty=1, count=0.
REQ-030 SHALL cover: write 16 words 0x00..0x0F, then a 17th word 0xFF with rd_en=0 -> full=1, count=16, overrun=1; pop all -> data 0x00..0x0F in order, 0xFF never appears.
REQ-031 SHALL cover: with full=1, rx_done=1 (0x55) and rd_en=1 in the same cycle -> count stays 16, overrun stays 0, 0x55 is read last.
REQ-032 SHALL cover: write 0x3C with rx_error=1 -> rd_err=1 while 0x3C is at the head; rd_en while empty -> count stays 0, no underflow.
REQ-033 SHALL cover: 40 interleaved write/pop cycles (pointer wrap) -> output order equals input order; assert rst mid-stream with count=5 -> count=0, overrun=0 next cycle.
REQ-034 SHALL cover, with UART_RX_FIFO_THRESH_IRQ_EN: rx_thresh=4 -> irq=0 at count 3 and irq=1 the cycle the 4th write lands; rx_thresh=0 with overrun=0 -> irq stays 0.
